crack_sched: RTL and testbench

CRACK_SCHED -- requirements
Module: crack_sched

---
 rtl/crack_sched_if.sv | 45 ++++
 rtl/crack_sched.sv | 176 +++++++++++++++++
 tb/tb_crack_sched.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/crack_sched_if.sv
// Bundle of scheduler-side and crack-core-side signals for crack_sched.
// slave = scheduler view, master = environment/core view.
interface crack_sched_if;
   localparam int unsigned KEY_W  = 24;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   logic              en;
   logic              rdy;
   logic [KEY_W-1:0]  key;
   logic              key_valid;
   logic [ADDR_W-1:0] ct_addr;
   logic [DATA_W-1:0] ct_rddata;

   logic              c0_en,        c1_en;
   logic              c0_rdy,       c1_rdy;
   logic              c0_key_valid, c1_key_valid;
   logic [KEY_W-1:0]  c0_key,       c1_key;
   logic [KEY_W-1:0]  c0_base,      c1_base;
   logic              c0_abort,     c1_abort;

   logic              c0_rd_req,    c1_rd_req;
   logic [ADDR_W-1:0] c0_rd_addr,   c1_rd_addr;
   logic              c0_rd_gnt,    c1_rd_gnt;
   logic [DATA_W-1:0] c0_rd_data,   c1_rd_data;
   logic              c0_rd_valid,  c1_rd_valid;

   modport slave (
      input  en, ct_rddata,
             c0_rdy, c1_rdy, c0_key_valid, c1_key_valid, c0_key, c1_key,
             c0_rd_req, c1_rd_req, c0_rd_addr, c1_rd_addr,
      output rdy, key, key_valid, ct_addr,
             c0_en, c1_en, c0_base, c1_base, c0_abort, c1_abort,
             c0_rd_gnt, c1_rd_gnt, c0_rd_data, c1_rd_data, c0_rd_valid, c1_rd_valid
   );

   modport master (
      output en, ct_rddata,
             c0_rdy, c1_rdy, c0_key_valid, c1_key_valid, c0_key, c1_key,
             c0_rd_req, c1_rd_req, c0_rd_addr, c1_rd_addr,
      input  rdy, key, key_valid, ct_addr,
             c0_en, c1_en, c0_base, c1_base, c0_abort, c1_abort,
             c0_rd_gnt, c1_rd_gnt, c0_rd_data, c1_rd_data, c0_rd_valid, c1_rd_valid
   );
endinterface

// File: rtl/crack_sched.sv
// Launches two crack cores on split key spaces, collects the first valid key,
// aborts the loser, and round-robin arbitrates their shared ciphertext reads.
module crack_sched (
   input  logic          clk,
   input  logic          rst_n,
   crack_sched_if.slave  bus
);
   localparam int unsigned KEY_W  = 24;
   localparam int unsigned ADDR_W = 8;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_RUN    = 2'd2;
   localparam logic [1:0] S_DRAIN  = 2'd3;

   logic [1:0]        r_state,     w_state_nxt;
   logic              r_rdy,       w_rdy_nxt;
   logic [KEY_W-1:0]  r_key,       w_key_nxt;
   logic              r_key_valid, w_key_valid_nxt;
   logic              r_c0_en,     w_c0_en_nxt;
   logic              r_c1_en,     w_c1_en_nxt;
   logic              r_c0_abort,  w_c0_abort_nxt;
   logic              r_c1_abort,  w_c1_abort_nxt;
   logic              r_done0,     w_done0_nxt;
   logic              r_done1,     w_done1_nxt;
   logic              r_c0_rdy_d;
   logic              r_c1_rdy_d;
   logic              w_rise0;
   logic              w_rise1;
   logic              w_win0;
   logic              w_win1;

   logic              r_rr;
   logic              w_gnt0;
   logic              w_gnt1;
   logic [ADDR_W-1:0] r_ct_addr;
   logic [ADDR_W-1:0] w_ct_addr;
   logic              r_rd_valid0;
   logic              r_rd_valid1;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rdy       <= 1'b0;
         r_key       <= '0;
         r_key_valid <= 1'b0;
         r_c0_en     <= 1'b0;
         r_c1_en     <= 1'b0;
         r_c0_abort  <= 1'b0;
         r_c1_abort  <= 1'b0;
         r_done0     <= 1'b0;
         r_done1     <= 1'b0;
         r_c0_rdy_d  <= 1'b0;
         r_c1_rdy_d  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rdy       <= w_rdy_nxt;
         r_key       <= w_key_nxt;
         r_key_valid <= w_key_valid_nxt;
         r_c0_en     <= w_c0_en_nxt;
         r_c1_en     <= w_c1_en_nxt;
         r_c0_abort  <= w_c0_abort_nxt;
         r_c1_abort  <= w_c1_abort_nxt;
         r_done0     <= w_done0_nxt;
         r_done1     <= w_done1_nxt;
         r_c0_rdy_d  <= bus.c0_rdy;
         r_c1_rdy_d  <= bus.c1_rdy;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_key_nxt       = r_key;
      w_key_valid_nxt = r_key_valid;
      w_c0_en_nxt     = 1'b0;
      w_c1_en_nxt     = 1'b0;
      w_c0_abort_nxt  = r_c0_abort;
      w_c1_abort_nxt  = r_c1_abort;
      w_done0_nxt     = r_done0;
      w_done1_nxt     = r_done1;
      w_rise0         = bus.c0_rdy & ~r_c0_rdy_d & ~r_done0;
      w_rise1         = bus.c1_rdy & ~r_c1_rdy_d & ~r_done1;
      w_win0          = w_rise0 & bus.c0_key_valid;
      w_win1          = w_rise1 & bus.c1_key_valid;

      case (r_state)
         S_IDLE: begin
            if (bus.en) begin
               w_key_valid_nxt = 1'b0;
               w_done0_nxt     = 1'b0;
               w_done1_nxt     = 1'b0;
               w_state_nxt     = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            if (bus.c0_rdy && bus.c1_rdy) begin
               w_c0_en_nxt = 1'b1;
               w_c1_en_nxt = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_done0_nxt = r_done0 | w_rise0;
            w_done1_nxt = r_done1 | w_rise1;
            // Core 0 takes priority on a simultaneous valid finish
            if (w_win0) begin
               w_key_nxt       = bus.c0_key;
               w_key_valid_nxt = 1'b1;
               w_c1_abort_nxt  = 1'b1;
               w_state_nxt     = S_DRAIN;
            end else if (w_win1) begin
               w_key_nxt       = bus.c1_key;
               w_key_valid_nxt = 1'b1;
               w_c0_abort_nxt  = 1'b1;
               w_state_nxt     = S_DRAIN;
            end else if (w_done0_nxt && w_done1_nxt) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DRAIN: begin
            if ((r_c0_abort && bus.c0_rdy) || (r_c1_abort && bus.c1_rdy)) begin
               w_c0_abort_nxt = 1'b0;
               w_c1_abort_nxt = 1'b0;
               w_state_nxt    = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_rdy_nxt = (w_state_nxt == S_IDLE);
   end

   // Read arbiter: r_rr=0 favours core 0 when both request
   always_comb begin
      w_gnt0    = rst_n & bus.c0_rd_req & (~bus.c1_rd_req | ~r_rr);
      w_gnt1    = rst_n & bus.c1_rd_req & (~bus.c0_rd_req |  r_rr);
      w_ct_addr = r_ct_addr;
      if (w_gnt0)      w_ct_addr = bus.c0_rd_addr;
      else if (w_gnt1) w_ct_addr = bus.c1_rd_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr        <= 1'b0;
         r_ct_addr   <= '0;
         r_rd_valid0 <= 1'b0;
         r_rd_valid1 <= 1'b0;
      end else begin
         if (w_gnt0)      r_rr <= 1'b1;
         else if (w_gnt1) r_rr <= 1'b0;
         r_ct_addr   <= w_ct_addr;
         r_rd_valid0 <= w_gnt0;
         r_rd_valid1 <= w_gnt1;
      end
   end

   assign bus.rdy         = r_rdy;
   assign bus.key         = r_key;
   assign bus.key_valid   = r_key_valid;
   assign bus.c0_en       = r_c0_en;
   assign bus.c1_en       = r_c1_en;
   assign bus.c0_abort    = r_c0_abort;
   assign bus.c1_abort    = r_c1_abort;
   assign bus.c0_base     = KEY_W'(24'h000000);
   assign bus.c1_base     = KEY_W'(24'h800000);
   assign bus.ct_addr     = w_ct_addr;
   assign bus.c0_rd_gnt   = w_gnt0;
   assign bus.c1_rd_gnt   = w_gnt1;
   assign bus.c0_rd_data  = bus.ct_rddata;
   assign bus.c1_rd_data  = bus.ct_rddata;
   assign bus.c0_rd_valid = r_rd_valid0;
   assign bus.c1_rd_valid = r_rd_valid1;

endmodule

// File: tb/tb_crack_sched.sv
// Directed bench for crack_sched: arbiter vector table plus hand-timed
// launch / finish / abort / reset sequences with a behavioural ct memory.
module tb_crack_sched;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   crack_sched_if bus ();

   crack_sched u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mem_f(input logic [7:0] a);
      return a ^ 8'hA5;
   endfunction

   // One-cycle-latency ciphertext memory
   always @(posedge clk) bus.ct_rddata <= mem_f(bus.ct_addr);

   typedef struct {
      logic       r0, r1;
      logic [7:0] a0, a1;
      logic       g0, g1;
      logic [7:0] ct;
      logic       v0, v1;
   } arb_vec_t;

   arb_vec_t av[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch_both();
      bus.en = 1'b1;
      step();
      bus.en = 1'b0;
      step();
      chk("launch_c0_en", 32'(bus.c0_en), 32'd1);
      chk("launch_c1_en", 32'(bus.c1_en), 32'd1);
      bus.c0_rdy = 1'b0;
      bus.c1_rdy = 1'b0;
      step();
   endtask

   logic [7:0] prev_ct;

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.c0_rdy = 1'b1;        bus.c1_rdy = 1'b1;
      bus.c0_key_valid = 1'b0;  bus.c1_key_valid = 1'b0;
      bus.c0_key = '0;          bus.c1_key = '0;
      bus.c0_rd_req = 1'b1;     bus.c1_rd_req = 1'b0;
      bus.c0_rd_addr = 8'h77;   bus.c1_rd_addr = 8'h00;

      av[0]  = '{1'b1, 1'b1, 8'h05, 8'h0A, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0};
      av[1]  = '{1'b1, 1'b1, 8'h05, 8'h0A, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0};
      av[2]  = '{1'b1, 1'b1, 8'h05, 8'h0A, 1'b1, 1'b0, 8'h05, 1'b0, 1'b1};
      av[3]  = '{1'b1, 1'b1, 8'h05, 8'h0A, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0};
      av[4]  = '{1'b0, 1'b0, 8'h05, 8'h0A, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b1};
      av[5]  = '{1'b0, 1'b1, 8'h05, 8'h0A, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b0};
      av[6]  = '{1'b0, 1'b1, 8'h05, 8'h0A, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b1};
      av[7]  = '{1'b1, 1'b1, 8'h33, 8'h0A, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1};
      av[8]  = '{1'b1, 1'b0, 8'h44, 8'h0A, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0};
      av[9]  = '{1'b0, 1'b0, 8'h44, 8'h0A, 1'b0, 1'b0, 8'h44, 1'b1, 1'b0};
      av[10] = '{1'b1, 1'b1, 8'h44, 8'h0A, 1'b0, 1'b1, 8'h0A, 1'b0, 1'b0};

      // Reset values, with a read request pending
      step();
      step();
      chk("rst_rdy",       32'(bus.rdy), 32'd0);
      chk("rst_key",       32'(bus.key), 32'd0);
      chk("rst_key_valid", 32'(bus.key_valid), 32'd0);
      chk("rst_c0_en",     32'(bus.c0_en), 32'd0);
      chk("rst_c1_abort",  32'(bus.c1_abort), 32'd0);
      chk("rst_ct_addr",   32'(bus.ct_addr), 32'd0);
      chk("rst_gnt0",      32'(bus.c0_rd_gnt), 32'd0);
      chk("rst_rd_valid0", 32'(bus.c0_rd_valid), 32'd0);
      chk("c0_base",       32'(bus.c0_base), 32'h000000);
      chk("c1_base",       32'(bus.c1_base), 32'h800000);
      bus.c0_rd_req = 1'b0;
      #2 rst_n = 1'b1;
      step();
      chk("rdy_after_rst", 32'(bus.rdy), 32'd1);

      // Arbiter vectors, served while idle
      prev_ct = 8'h00;
      for (int i = 0; i < 11; i++) begin
         bus.c0_rd_req  = av[i].r0;
         bus.c1_rd_req  = av[i].r1;
         bus.c0_rd_addr = av[i].a0;
         bus.c1_rd_addr = av[i].a1;
         #2;
         chk($sformatf("arb%0d_gnt0", i), 32'(bus.c0_rd_gnt), 32'(av[i].g0));
         chk($sformatf("arb%0d_gnt1", i), 32'(bus.c1_rd_gnt), 32'(av[i].g1));
         chk($sformatf("arb%0d_ct_addr", i), 32'(bus.ct_addr), 32'(av[i].ct));
         chk($sformatf("arb%0d_valid0", i), 32'(bus.c0_rd_valid), 32'(av[i].v0));
         chk($sformatf("arb%0d_valid1", i), 32'(bus.c1_rd_valid), 32'(av[i].v1));
         if (av[i].v0) chk($sformatf("arb%0d_data0", i), 32'(bus.c0_rd_data), 32'(mem_f(prev_ct)));
         if (av[i].v1) chk($sformatf("arb%0d_data1", i), 32'(bus.c1_rd_data), 32'(mem_f(prev_ct)));
         prev_ct = av[i].ct;
         step();
      end
      bus.c0_rd_req = 1'b0;
      bus.c1_rd_req = 1'b0;

      // Core 0 finds key, core 1 aborted
      chk("a_idle_rdy", 32'(bus.rdy), 32'd1);
      bus.en = 1'b1;
      step();
      bus.en = 1'b0;
      chk("a_rdy_low", 32'(bus.rdy), 32'd0);
      chk("a_no_en_yet", 32'(bus.c0_en), 32'd0);
      step();
      chk("a_c0_en", 32'(bus.c0_en), 32'd1);
      chk("a_c1_en", 32'(bus.c1_en), 32'd1);
      bus.c0_rdy = 1'b0;
      bus.c1_rdy = 1'b0;
      step();
      chk("a_en_one_cycle", 32'({bus.c0_en, bus.c1_en}), 32'd0);
      step();
      bus.c0_rdy = 1'b1; bus.c0_key_valid = 1'b1; bus.c0_key = 24'h000001;
      step();
      bus.c0_key_valid = 1'b0;
      chk("a_key", 32'(bus.key), 32'h000001);
      chk("a_key_valid", 32'(bus.key_valid), 32'd1);
      chk("a_c1_abort", 32'(bus.c1_abort), 32'd1);
      chk("a_c0_abort", 32'(bus.c0_abort), 32'd0);
      step();
      chk("a_abort_held", 32'(bus.c1_abort), 32'd1);
      chk("a_rdy_drain", 32'(bus.rdy), 32'd0);
      bus.c1_rdy = 1'b1; bus.c1_key_valid = 1'b1; bus.c1_key = 24'hABCDEF;
      step();
      bus.c1_key_valid = 1'b0;
      chk("a_rdy_done", 32'(bus.rdy), 32'd1);
      chk("a_abort_off", 32'(bus.c1_abort), 32'd0);
      chk("a_key_kept", 32'(bus.key), 32'h000001);

      // Both finish together with valid keys: core 0 wins
      launch_both();
      step();
      bus.c0_rdy = 1'b1; bus.c1_rdy = 1'b1;
      bus.c0_key_valid = 1'b1; bus.c1_key_valid = 1'b1;
      bus.c0_key = 24'h123456; bus.c1_key = 24'h800001;
      step();
      bus.c0_key_valid = 1'b0; bus.c1_key_valid = 1'b0;
      chk("b_key", 32'(bus.key), 32'h123456);
      chk("b_c1_abort", 32'(bus.c1_abort), 32'd1);
      chk("b_c0_abort", 32'(bus.c0_abort), 32'd0);
      step();
      chk("b_rdy", 32'(bus.rdy), 32'd1);
      chk("b_abort_off", 32'(bus.c1_abort), 32'd0);

      // Launch waits for core 1; both finish invalid at different times
      bus.c1_rdy = 1'b0;
      bus.en = 1'b1;
      step();
      bus.en = 1'b0;
      chk("c_kv_cleared", 32'(bus.key_valid), 32'd0);
      step();
      chk("c_launch_wait", 32'(bus.c0_en), 32'd0);
      bus.c1_rdy = 1'b1;
      step();
      chk("c_c0_en", 32'(bus.c0_en), 32'd1);
      bus.c0_rdy = 1'b0; bus.c1_rdy = 1'b0;
      step();
      step();
      bus.c1_rdy = 1'b1;
      step();
      chk("c_one_done_busy", 32'(bus.rdy), 32'd0);
      step();
      bus.c0_rdy = 1'b1;
      step();
      chk("c_rdy", 32'(bus.rdy), 32'd1);
      chk("c_key_valid", 32'(bus.key_valid), 32'd0);
      chk("c_key_unchanged", 32'(bus.key), 32'h123456);

      // Core 1 wins; en during run is ignored
      launch_both();
      bus.en = 1'b1;
      step();
      bus.en = 1'b0;
      chk("d_en_ignored_rdy", 32'(bus.rdy), 32'd0);
      chk("d_en_ignored_c0en", 32'(bus.c0_en), 32'd0);
      bus.c1_rdy = 1'b1; bus.c1_key_valid = 1'b1; bus.c1_key = 24'h800123;
      step();
      bus.c1_key_valid = 1'b0;
      chk("d_key", 32'(bus.key), 32'h800123);
      chk("d_c0_abort", 32'(bus.c0_abort), 32'd1);
      chk("d_c1_abort", 32'(bus.c1_abort), 32'd0);
      step();
      chk("d_abort_held", 32'(bus.c0_abort), 32'd1);
      bus.c0_rdy = 1'b1;
      step();
      chk("d_rdy", 32'(bus.rdy), 32'd1);
      chk("d_abort_off", 32'(bus.c0_abort), 32'd0);

      // Reset while draining
      launch_both();
      bus.c0_rdy = 1'b1; bus.c0_key_valid = 1'b1; bus.c0_key = 24'h000ABC;
      step();
      bus.c0_key_valid = 1'b0;
      chk("e_abort_pre", 32'(bus.c1_abort), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("e_rst_rdy", 32'(bus.rdy), 32'd0);
      chk("e_rst_kv", 32'(bus.key_valid), 32'd0);
      chk("e_rst_abort", 32'(bus.c1_abort), 32'd0);
      chk("e_rst_key", 32'(bus.key), 32'd0);
      step();
      chk("e_rst_rdy_hold", 32'(bus.rdy), 32'd0);
      bus.c1_rdy = 1'b1;
      #2 rst_n = 1'b1;
      step();
      chk("e_rdy_after", 32'(bus.rdy), 32'd1);
      chk("e_no_en", 32'(bus.c0_en), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
